// File: rtl/result_drain_pkg.sv
// Shared types and default sizing for the PE result-cache drain stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package result_drain_pkg;

    localparam int NUM_CH = 8;
    localparam int BEATS  = 8;
    localparam int DW     = 16;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } drain_state_t;

    // One buffered beat: last flags the final beat of the final channel.
    typedef struct packed {
        logic            last;
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   data;
    } drain_beat_t;

endpackage

// File: rtl/result_drain_fifo.sv
// Show-ahead FIFO of drain beats with an occupancy count for the issue space check.
// Latency: a beat pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: pop only when non-empty; the writer guarantees space, so a push while full is a bug.
module result_drain_fifo
    import result_drain_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  drain_beat_t              din,
    input  logic                     pop,
    output drain_beat_t              dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    drain_beat_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    // Head reads as zero while empty so the output fields have a defined idle value.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents need no reset since the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/result_drain_arb.sv
// Drains the eight result-cache channels in order into one tagged valid/ready stream.
// Latency: start -> rd_sop[0] next cycle; a beat reaches out_* one cycle after it is captured.
// Backpressure: channels are issued only with room for a full burst; optional checking under RESULT_DRAIN_ERR_EN.
module result_drain_arb #(
    parameter int NUM_CH     = result_drain_pkg::NUM_CH,
    parameter int BEATS      = result_drain_pkg::BEATS,
    parameter int DW         = result_drain_pkg::DW,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         rd_sop,
    input  logic [NUM_CH-1:0]         rd_vld,
    input  logic [NUM_CH-1:0]         rd_eop,
    input  logic [NUM_CH*DW-1:0]      rd_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [DW-1:0]             out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      proto_err
);

    import result_drain_pkg::*;

    localparam int CW  = $clog2(NUM_CH);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t   state;
    drain_state_t   state_nxt;
    logic [CW-1:0]  ch;
    logic [CW-1:0]  ch_nxt;

    logic           sel_vld;
    logic           sel_eop;
    logic [DW-1:0]  sel_data;
    logic           last_ch;
    logic           space_ok;

    logic           push;
    logic           pop;
    drain_beat_t    push_beat;
    drain_beat_t    head;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    assign sel_vld   = rd_vld[ch];
    assign sel_eop   = rd_eop[ch];
    assign sel_data  = rd_data[ch*DW +: DW];
    assign last_ch   = (ch == CW'(NUM_CH-1));
    // The cache cannot be stalled, so a whole burst must fit before it is requested.
    assign space_ok  = (fifo_count <= FCW'(FIFO_DEPTH-BEATS));
    assign push_beat = '{last: sel_eop && last_ch, ch: ch, data: sel_data};
    assign pop       = out_vld && out_rdy;
    assign busy      = (state != IDLE);

    // State and current-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // Sequencing: issue one channel, collect its burst, repeat, then wait for the FIFO to empty.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        rd_sop    = '0;
        push      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ch_nxt    = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (space_ok) begin
                    rd_sop[ch] = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (sel_vld) begin
                    push = 1'b1;
                    if (sel_eop) begin
                        if (last_ch) begin
                            state_nxt = DRAIN;
                        end else begin
                            ch_nxt    = ch + 1'b1;
                            state_nxt = ISSUE;
                        end
                    end
                end
            end
            DRAIN: begin
                // Finish in the same cycle the final beat is handed off.
                if (fifo_empty || (fifo_count == FCW'(1) && pop)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    result_drain_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_vld  = !fifo_empty;
    assign out_data = head.data;
    assign out_ch   = head.ch;
    assign out_last = head.last;

`ifdef RESULT_DRAIN_ERR_EN
    localparam int BCW = $clog2(BEATS) + 1;

    logic [BCW-1:0] beat_cnt;
    logic           stray;
    logic           err_now;

    // Flag beats from unselected channels, beats outside a burst, and malformed burst lengths.
    always_comb begin
        stray   = (state == WAIT) ? |(rd_vld & ~(NUM_CH'(1) << ch)) : |rd_vld;
        err_now = stray
               || ((state == WAIT) && sel_vld && !sel_eop && (beat_cnt == BCW'(BEATS-1)))
               || ((state == WAIT) && sel_vld &&  sel_eop && (beat_cnt <  BCW'(BEATS-1)));
    end

    // Per-burst beat counter and sticky error, both cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else if (state == IDLE && start) begin
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push)    beat_cnt  <= sel_eop ? '0 : beat_cnt + 1'b1;
            if (err_now) proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_drain_arb.sv
`timescale 1ns/1ps
module tb_result_drain_arb;

    localparam int NUM_CH = 8, BEATS = 8, DW = 16, FIFO_DEPTH = 16;
    localparam int TOTAL  = NUM_CH * BEATS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 out_rdy;
    logic                 busy, done, out_vld, out_last, proto_err;
    logic [NUM_CH-1:0]    rd_sop, rd_vld, rd_eop;
    logic [NUM_CH*DW-1:0] rd_data;
    logic [DW-1:0]        out_data;
    logic [2:0]           out_ch;

    result_drain_arb #(.NUM_CH(NUM_CH), .BEATS(BEATS), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop), .rd_data(rd_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .proto_err(proto_err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cache responder: answers each rd_sop with an 8-beat burst
    int   beats_left = 0;
    int   cur_ch     = 0;
    int   sop_count  = 0;
    int   stray_on_ch = -1;
    int   stray_ch    = 5;
    logic stray_fired = 1'b0;
    logic drv_sel     = 1'b0;

    initial begin
        int bi;
        rd_vld  = '0;
        rd_eop  = '0;
        rd_data = '0;
        forever begin
            @(posedge clk); #1;
            rd_vld  = '0;
            rd_eop  = '0;
            drv_sel = 1'b0;
            for (int k = 0; k < NUM_CH; k++) rd_data[k*DW +: DW] = 16'hDEAD;
            if (!rst_n) begin
                beats_left = 0;
            end else if (beats_left > 0) begin
                chk("sop_during_burst", rd_sop, 0);
                bi = BEATS - beats_left;
                rd_vld[cur_ch] = 1'b1;
                rd_eop[cur_ch] = (bi == BEATS-1);
                rd_data[cur_ch*DW +: DW] = DW'(cur_ch*BEATS + bi);
                drv_sel = 1'b1;
                if (cur_ch == stray_on_ch && bi == 3) begin
                    rd_vld[stray_ch] = 1'b1;
                    rd_data[stray_ch*DW +: DW] = 16'hBAD5;
                    stray_fired = 1'b1;
                end
                beats_left--;
            end else if (rd_sop != '0) begin
                chk("sop_order_onehot", rd_sop, 32'(1) << sop_count);
                cur_ch     = sop_count;
                sop_count++;
                beats_left = BEATS;
            end
        end
    end

    // ---------------- consumer ready: 0 = stalled, 1 = always, 2 = 30% random
    int rdy_mode = 1;
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_rdy = 1'b0;
                1:       out_rdy = 1'b1;
                default: out_rdy = ($urandom_range(99, 0) < 30);
            endcase
        end
    end

    // ---------------- reference model + per-cycle compare
    // Expected stream is simply beat index 0..63: data = index, ch = index/8, last on 63.
    int            exp_idx  = 0;
    int            done_cnt = 0;
    int            occ      = 0;
    logic          busy_exp = 1'b0;
    logic          perr_exp = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [2:0]    prev_ch;
    logic          prev_last;
    logic          hs;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_idx = 0; occ = 0; busy_exp = 1'b0; perr_exp = 1'b0; prev_stall = 1'b0;
            end else begin
                hs = out_vld && out_rdy;
                chk("busy", busy, busy_exp);
                chk("proto_err", proto_err, perr_exp);
                chk("out_vld_vs_occupancy", out_vld, occ > 0);
                if (rd_sop != '0) chk("sop_needs_space", occ <= FIFO_DEPTH - BEATS, 1);
                if (prev_stall) begin
                    chk("stall_vld", out_vld, 1);
                    chk("stall_data", out_data, prev_data);
                    chk("stall_ch", out_ch, prev_ch);
                    chk("stall_last", out_last, prev_last);
                end
                if (hs) begin
                    chk("out_data", out_data, exp_idx);
                    chk("out_ch", out_ch, exp_idx / BEATS);
                    chk("out_last", out_last, exp_idx == TOTAL-1);
                    chk("done_on_last", done, exp_idx == TOTAL-1);
                    if (exp_idx == TOTAL-1) begin
                        done_cnt++;
                        busy_exp = 1'b0;
                    end
                    exp_idx++;
                end else begin
                    chk("done_quiet", done, 0);
                end
                prev_stall = out_vld && !out_rdy;
                prev_data  = out_data;
                prev_ch    = out_ch;
                prev_last  = out_last;
                occ = occ + (drv_sel ? 1 : 0) - (hs ? 1 : 0);
                if (stray_fired) begin
`ifdef RESULT_DRAIN_ERR_EN
                    perr_exp = 1'b1;
`endif
                    stray_fired = 1'b0;
                end
                if (start && !busy_exp) begin
                    busy_exp = 1'b1;
                    perr_exp = 1'b0;
                    exp_idx  = 0;
                end
            end
        end
    end

    // ---------------- helpers
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < maxc) begin
            @(posedge clk);
            c++;
        end
        chk({name, "_done_seen"}, done_cnt != d0, 1);
        @(posedge clk); #1;
        chk({name, "_idle_after"}, busy, 0);
        chk({name, "_beats"}, exp_idx, TOTAL);
        chk({name, "_sops"}, sop_count, NUM_CH);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rd_sop"}, rd_sop, 0);
        chk({name, "_out_vld"}, out_vld, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_ch"}, out_ch, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_proto_err"}, proto_err, 0);
    endtask

    // ---------------- directed sequence
    initial begin
        int d0;
        int c;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Nominal run with literal latency pins.
        sop_count = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nom_sop0_at_T+1", rd_sop, 8'h01);
        chk("nom_busy_at_T+1", busy, 1);
        @(posedge clk); #1;
        chk("nom_vld_low_at_T+2", out_vld, 0);
        @(posedge clk); #1;
        chk("nom_vld_at_T+3", out_vld, 1);
        chk("nom_head0", out_data, 16'h0000);
        wait_done(2000, "nom");
        chk("nom_done_count", done_cnt, 1);

        // Consumer stalled: only two bursts fit in 16 entries.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        sop_count = 0;
        pulse_start();
        repeat (60) @(posedge clk);
        #1;
        chk("bp_sops_withheld", sop_count, 2);
        chk("bp_head_vld", out_vld, 1);
        chk("bp_head_data", out_data, 16'h0000);
        chk("bp_busy", busy, 1);
        rdy_mode = 1;
        wait_done(2000, "bp");

        // Random 30% ready.
        rdy_mode = 2;
        sop_count = 0;
        pulse_start();
        wait_done(4000, "rnd");
        rdy_mode = 1;

        // start while busy must be ignored.
        d0 = done_cnt;
        sop_count = 0;
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            repeat (12) @(posedge clk);
            pulse_start();
        end
        wait_done(2000, "rebusy");
        repeat (20) @(posedge clk);
        chk("rebusy_single_done", done_cnt, d0 + 1);
        chk("rebusy_sops", sop_count, NUM_CH);

        // Stray beat from channel 5 during the channel-2 burst.
        stray_on_ch = 2;
        sop_count = 0;
        pulse_start();
        wait_done(2000, "stray");
        stray_on_ch = -1;
`ifdef RESULT_DRAIN_ERR_EN
        chk("stray_proto_err", proto_err, 1);
`else
        chk("stray_proto_err", proto_err, 0);
`endif
        sop_count = 0;
        pulse_start();
        chk("stray_cleared_by_start", proto_err, 0);
        wait_done(2000, "after_stray");

        // Reset in the middle of a run.
        sop_count = 0;
        pulse_start();
        c = 0;
        while (exp_idx < 20 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        chk("mid_reached_20", exp_idx >= 20, 1);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        sop_count = 0;
        pulse_start();
        wait_done(2000, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_drain_arb.md
# result_drain_arb

Downstream drain stage for the PE result cache. After each cache load it requests the eight per-column result streams in turn with `rd_sop_k`, and collects each 8-beat burst (`rd_vld_k`/`rd_data_k`/`rd_eop_k`). The beats are buffered in a small FIFO and emitted as one tagged valid/ready stream to the writeback path. Channels are issued only when FIFO space for a full burst is guaranteed, because the cache read path has no backpressure.

## Interface
- `NUM_CH`, 8, number of cache channels
- `BEATS`, 8, words per channel burst
- `DW`, 16, data width
- `FIFO_DEPTH`, 16, output FIFO entries (power of 2, ≥ `BEATS`)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: cache freshly loaded (issued one cycle after `save_sop`)
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last beat has left the FIFO
- `rd_sop`  out  `NUM_CH`  one-hot read-start pulse per channel
- `rd_vld`  in  `NUM_CH`  beat valid per channel
- `rd_eop`  in  `NUM_CH`  last-beat flag per channel
- `rd_data`  in  `NUM_CH*DW`  channel k at `[k*DW +: DW]`
- `out_vld`  out  1  FIFO head valid
- `out_rdy`  in  1  consumer accept
- `out_data`  out  `DW`  beat data
- `out_ch`  out  `$clog2(NUM_CH)`  source channel of beat
- `out_last`  out  1  final beat of channel `NUM_CH-1`
- `proto_err`  out  1  sticky protocol error; cleared by accepted `start`

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `DRAIN`.
- `IDLE`: an accepted `start` sets `ch`=0, clears the beat count and `proto_err`, and moves to `ISSUE`. `start` while `busy` is ignored.
- `ISSUE`: if `fifo_count ≤ FIFO_DEPTH-BEATS`, `rd_sop[ch]`=1 for this cycle and the FSM moves to `WAIT`; otherwise it stalls in `ISSUE`.
- `WAIT`:
  - Each cycle with `rd_vld[ch]`=1 pushes `{last, ch, rd_data[ch]}` and increments the beat count.
  - `last` = `rd_eop[ch]` && `ch`==`NUM_CH-1`.
  - On `rd_vld[ch]`&&`rd_eop[ch]`: if `ch`==`NUM_CH-1`, go to `DRAIN`; otherwise `ch`++, clear the beat count, and go to `ISSUE`.
- `DRAIN`: when the FIFO is empty (including the cycle the final pop completes), pulse `done` and go to `IDLE`.
- `busy` = state ≠ `IDLE`.
- Output stream:
  - FIFO is show-ahead: `out_vld` = !empty, and the `out_*` fields reflect the head entry.
  - Pop on `out_vld`&&`out_rdy`.
  - Head must stay stable while `out_vld`&&!`out_rdy`.
- Push and pop in the same cycle are allowed: count unchanged.
- The FIFO can never overflow because of the `ISSUE` space check; a push while full is an assertion failure.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_sop`=0, `out_vld`=0, `out_data`=0, `out_ch`=0, `out_last`=0, `proto_err`=0; state=`IDLE`; FIFO empty.
- `start` at cycle T gives state `ISSUE` at T+1, with `rd_sop[0]` high at T+1 if space is available.
- A beat pushed at cycle N has `out_vld` high at N+1 when the FIFO was empty.
- Back-to-back channels: the cycle after `rd_eop[k]` is `ISSUE` for k+1.
- Minimum gap between a burst end and the next `rd_sop` is 1 cycle.
- Reset mid-operation discards all FIFO contents and in-flight beats immediately; the cache is not notified.
- `rd_sop` is a one-cycle pulse, never asserted on two channels at once.

## Configuration
- `RESULT_DRAIN_ERR_EN` defined: protocol checking is compiled in. `proto_err` sets on any of:
  - `rd_vld[j]` with j ≠ `ch`, or any `rd_vld` in `IDLE`/`ISSUE`/`DRAIN`;
  - beat count reaching `BEATS` without `rd_eop`;
  - `rd_eop` with beat count < `BEATS-1`.
- Stray beats that set `proto_err` are not pushed.
- Undefined: checking logic is absent and `proto_err` is tied 0. Non-selected `rd_vld` is still ignored. Only `rd_eop[ch]` ends a burst.

## Structure
- Package `result_drain_pkg`:
  - `drain_state_t` enum (`IDLE`, `ISSUE`, `WAIT`, `DRAIN`);
  - default constants `NUM_CH`, `BEATS`, `DW`;
  - `drain_beat_t` struct `{last, ch, data}`.
- Sub-module `result_drain_fifo`: synchronous show-ahead FIFO of `drain_beat_t`, with a `count` output and the same `clk`/`rst_n`.

## Test plan
- Nominal: `start`, model returns 8 beats per channel with data 16'h(k*8+i), `out_rdy`=1 → 64 beats in order; `out_ch` follows 0..7; `out_last` only on beat 63; one `done` pulse.
- Backpressure: `out_rdy`=0 throughout → exactly 2 channels accepted (FIFO 16 entries), `rd_sop[2]` withheld. After that, `out_rdy`=1 → completes with data intact.
- Random `out_rdy` at 30% → head stable during stalls; 64 beats, none lost or duplicated.
- `start` while `busy` → ignored; a single `done`; `rd_sop` sequence unchanged.
- With `RESULT_DRAIN_ERR_EN`: stray `rd_vld[5]` during the channel-2 burst → `proto_err`=1, beat not in stream; next `start` clears it.
- Reset asserted after 20 beats → next cycle all outputs at reset values and FIFO empty; a new `start` gives a full clean 64-beat run.
